// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - SHA-256 schedule types, round constants and sigma helpers
package sha256_pkg;

   typedef logic [31:0] word_t;

   localparam int NUM_ROUNDS  = 64;
   localparam int BLOCK_WORDS = 16;

   typedef enum logic [1:0] {
      LOAD,
      EXPAND,
      DRAIN
   } sched_state_e;

   localparam word_t K [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
      32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
      32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
      32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
      32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
      32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   // Small sigmas: rotates are fixed bit slices, the shifts fill with zeros
   function automatic word_t sigma0(input word_t x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
   endfunction

   function automatic word_t sigma1(input word_t x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
   endfunction

endpackage

// File: rtl/sha256_msg_schedule_expansion.sv
// rtl/sha256_msg_schedule_expansion.sv - W_t = s1(W_t-2) + W_t-7 + s0(W_t-15) + W_t-16
module sha256_msg_schedule_expansion
   import sha256_pkg::*;
(
   input  word_t wkk16_i,
   input  word_t wkk15_i,
   input  word_t wkk7_i,
   input  word_t wkk2_i,
   output word_t wkk_o
);

   word_t s0, s1;
   word_t sum_a, car_a, sum_b, car_b;

   assign s0 = sigma0(wkk15_i);
   assign s1 = sigma1(wkk2_i);

   // Two carry-save stages reduce four operands to two; carries out of bit 31 are dropped
   assign sum_a = s1 ^ wkk7_i ^ s0;
   assign car_a = ((s1 & wkk7_i) | (s1 & s0) | (wkk7_i & s0)) << 1;
   assign sum_b = sum_a ^ car_a ^ wkk16_i;
   assign car_b = ((sum_a & car_a) | (sum_a & wkk16_i) | (car_a & wkk16_i)) << 1;

   assign wkk_o = sum_b + car_b;

endmodule

// File: rtl/sha256_msg_schedule.sv
// rtl/sha256_msg_schedule.sv - SHA-256 message schedule W0..W63; SHA256_SCHED_KADD_EN emits W_t+K[t]
module sha256_msg_schedule
   import sha256_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        clear_i,
   input  logic [31:0] blk_word_i,
   input  logic        blk_valid_i,
   output logic        blk_ready_o,
   output logic [31:0] w_o,
   output logic [5:0]  w_idx_o,
   output logic        w_valid_o,
   input  logic        w_ready_i,
   output logic        busy_o,
   output logic        done_o
);

   localparam logic [5:0] LAST_LOAD  = 6'(BLOCK_WORDS - 1);
   localparam logic [5:0] LAST_ROUND = 6'(NUM_ROUNDS - 1);

   sched_state_e state_q, state_d;
   logic [5:0]   t_q, t_d;
   word_t        win_q [BLOCK_WORDS];
   word_t        w_d;
   logic [5:0]   idx_d;
   logic         valid_d;
   logic         slot_free;
   logic         shift_en;
   word_t        wkk;
   word_t        new_word;
   word_t        out_word;

   sha256_msg_schedule_expansion u_expansion (
      .wkk16_i (win_q[0]),
      .wkk15_i (win_q[1]),
      .wkk7_i  (win_q[9]),
      .wkk2_i  (win_q[14]),
      .wkk_o   (wkk)
   );

   assign slot_free = !w_valid_o | w_ready_i;
   assign new_word  = (state_q == EXPAND) ? wkk : blk_word_i;

`ifdef SHA256_SCHED_KADD_EN
   assign out_word = new_word + K[t_q];
`else
   assign out_word = new_word;
`endif

   always_comb begin
      state_d     = state_q;
      t_d         = t_q;
      w_d         = w_o;
      idx_d       = w_idx_o;
      valid_d     = w_valid_o & !w_ready_i;
      blk_ready_o = 1'b0;
      done_o      = 1'b0;
      shift_en    = 1'b0;
      if (clear_i) begin
         state_d = LOAD;
         t_d     = '0;
         valid_d = 1'b0;
      end else begin
         case (state_q)
            LOAD: begin
               blk_ready_o = slot_free;
               if (blk_valid_i && slot_free) begin
                  shift_en = 1'b1;
                  t_d      = t_q + 6'd1;
                  if (t_q == LAST_LOAD) state_d = EXPAND;
               end
            end
            EXPAND: begin
               if (slot_free) begin
                  shift_en = 1'b1;
                  t_d      = t_q + 6'd1;
                  if (t_q == LAST_ROUND) state_d = DRAIN;
               end
            end
            DRAIN: begin
               // W63 is still parked in the output register until it is taken
               if (w_valid_o && w_ready_i) begin
                  done_o  = 1'b1;
                  t_d     = '0;
                  state_d = LOAD;
               end
            end
            default: state_d = LOAD;
         endcase
      end
      if (shift_en) begin
         w_d     = out_word;
         idx_d   = t_q;
         valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= LOAD;
         t_q       <= '0;
         w_o       <= '0;
         w_idx_o   <= '0;
         w_valid_o <= 1'b0;
      end else begin
         state_q   <= state_d;
         t_q       <= t_d;
         w_o       <= w_d;
         w_idx_o   <= idx_d;
         w_valid_o <= valid_d;
      end
   end

   // The window always holds raw W so the expansion never sees K
   always_ff @(posedge clk_i) begin
      if (shift_en) begin
         for (int i = 0; i < BLOCK_WORDS - 1; i++) win_q[i] <= win_q[i+1];
         win_q[BLOCK_WORDS-1] <= new_word;
      end
   end

   assign busy_o = (state_q != LOAD) | (t_q != 6'd0) | w_valid_o;

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// tb/tb_sha256_msg_schedule.sv - directed bench for sha256_msg_schedule
module tb_sha256_msg_schedule;

   logic        clk_i;
   logic        rst_ni;
   logic        clear_i;
   logic [31:0] blk_word_i;
   logic        blk_valid_i;
   logic        blk_ready_o;
   logic [31:0] w_o;
   logic [5:0]  w_idx_o;
   logic        w_valid_o;
   logic        w_ready_i;
   logic        busy_o;
   logic        done_o;

   logic [31:0] msg     [16];
   logic [31:0] exp_out [64];
   logic [31:0] obs     [64];
   int          n_assert;
   int          n_fail;
   int          first_hs;
   int          last_hs;

   sha256_msg_schedule dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .clear_i     (clear_i),
      .blk_word_i  (blk_word_i),
      .blk_valid_i (blk_valid_i),
      .blk_ready_o (blk_ready_o),
      .w_o         (w_o),
      .w_idx_o     (w_idx_o),
      .w_valid_o   (w_valid_o),
      .w_ready_i   (w_ready_i),
      .busy_o      (busy_o),
      .done_o      (done_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_assert++;
      assert (observed === expected)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   task automatic build_expected();
      logic [31:0] w [64];
      for (int i = 0; i < 64; i++) begin
         if (i < 16) w[i] = msg[i];
         else w[i] = (rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10))
                   + w[i-7]
                   + (rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3))
                   + w[i-16];
`ifdef SHA256_SCHED_KADD_EN
         exp_out[i] = w[i] + sha256_pkg::K[i];
`else
         exp_out[i] = w[i];
`endif
      end
   endtask

   task automatic set_abc();
      for (int i = 0; i < 16; i++) msg[i] = 32'h0;
      msg[0]  = 32'h61626380;
      msg[15] = 32'h00000018;
      build_expected();
   endtask

   // Streams one block; returns with word stop_idx presented (valid) when stop_idx < 64
   task automatic run_block(input bit gaps, input int stall_idx, input int stall_len,
                            input int stop_idx, input bit junk);
      int          li = 0;
      int          oi = 0;
      int          cyc = 0;
      int          stall_left = stall_len;
      logic [31:0] held = 32'h0;
      first_hs = -1;
      last_hs  = -1;
      while (oi < 64 && oi != stop_idx && cyc < 1000) begin
         if (li < 16) begin
            blk_valid_i = !(gaps && (cyc % 2 == 1));
            blk_word_i  = msg[li];
         end else begin
            blk_valid_i = junk;
            blk_word_i  = 32'hDEADBEEF;
         end
         w_ready_i = 1'b1;
         if (w_valid_o && 32'(w_idx_o) == stall_idx && stall_left > 0) begin
            if (stall_left == stall_len) held = w_o;
            else check("stall_hold_w", w_o, held);
            w_ready_i = 1'b0;
            stall_left--;
         end
         #1;
         if (li >= 16) check("blk_ready_outside_load", 32'(blk_ready_o), 32'h0);
         check("done_pulse", 32'(done_o), 32'(w_valid_o && w_ready_i && oi == 63));
         if (w_valid_o && w_ready_i) begin
            check("w_idx_order", 32'(w_idx_o), 32'(oi));
            check("w_value", w_o, exp_out[oi]);
            obs[oi] = w_o;
            if (first_hs < 0) first_hs = cyc;
            last_hs = cyc;
            oi++;
         end
         if (blk_valid_i && blk_ready_o) li++;
         @(posedge clk_i);
         #1;
         cyc++;
      end
      blk_valid_i = 1'b0;
      check("block_progress", 32'(oi), 32'((stop_idx < 64) ? stop_idx : 64));
   endtask

   task automatic check_idle(input string tag);
      #1;
      check({tag, "_valid"}, 32'(w_valid_o), 32'h0);
      check({tag, "_busy"}, 32'(busy_o), 32'h0);
      check({tag, "_ready"}, 32'(blk_ready_o), 32'h1);
      check({tag, "_done"}, 32'(done_o), 32'h0);
   endtask

   initial begin
      n_assert    = 0;
      n_fail      = 0;
      rst_ni      = 1'b0;
      clear_i     = 1'b0;
      blk_valid_i = 1'b0;
      blk_word_i  = 32'h0;
      w_ready_i   = 1'b1;
      repeat (3) @(posedge clk_i);
      #1;
      check("rst_w", w_o, 32'h0);
      check("rst_idx", 32'(w_idx_o), 32'h0);
      check_idle("rst");
      rst_ni = 1'b1;
      @(posedge clk_i);
      #1;

      // 1: "abc" block at full rate, junk offered on blk_valid_i during expansion
      set_abc();
      run_block(1'b0, -1, 0, 64, 1'b1);
      check("abc_span", 32'(last_hs - first_hs), 32'd63);
`ifdef SHA256_SCHED_KADD_EN
      check("kadd_w0", obs[0], 32'hA3EC9318);
`else
      check("abc_w16", obs[16], 32'h61626380);
      check("abc_w17", obs[17], 32'h000F0000);
`endif
      check_idle("abc_end");

      // 2: five cycles of backpressure on W20
      run_block(1'b0, 20, 5, 64, 1'b0);
      check("stall_span", 32'(last_hs - first_hs), 32'd68);
      check_idle("stall_end");

      // 3: input gaps during load
      run_block(1'b1, -1, 0, 64, 1'b0);
      check_idle("gap_end");

      // 4: clear while W30 is presented
      run_block(1'b0, -1, 0, 30, 1'b0);
      clear_i = 1'b1;
      @(posedge clk_i);
      #1;
      clear_i = 1'b0;
      check_idle("clear");
      run_block(1'b0, -1, 0, 64, 1'b0);
      check("after_clear_span", 32'(last_hs - first_hs), 32'd63);

      // 5: asynchronous reset while W40 is presented, then a different block
      run_block(1'b0, -1, 0, 40, 1'b0);
      rst_ni = 1'b0;
      #1;
      check("async_rst_w", w_o, 32'h0);
      check("async_rst_idx", 32'(w_idx_o), 32'h0);
      check_idle("async_rst");
      @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      @(posedge clk_i);
      #1;
      for (int i = 0; i < 16; i++) msg[i] = (32'h01234567 * (i + 1)) ^ 32'h9E3779B9;
      build_expected();
      run_block(1'b0, -1, 0, 64, 1'b1);
      check("rand_span", 32'(last_hs - first_hs), 32'd63);
      check_idle("rand_end");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
